md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Multiply/divide sequencer for the EX stage of the five-stage pipeline.
- Accepts one mult/div/move operation per cycle from EX and models the unit's multi-cycle latency with a countdown.
- Owns the HI/LO registers.
- Raises a stall toward the hazard logic whenever an ID-stage mult/div-class instruction must wait for the unit.

Parameters:
- MUL_LAT, 5, busy cycles after a mult/multu start (>=1)
- DIV_LAT, 10, busy cycles after a div/divu start (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- op_valid  input  1  EX-stage instruction is a mult/div-class op
- op  input  4  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; other codes are no-ops
- a  input  32  forwarded rs value (EXRD1F)
- b  input  32  forwarded rt value
- id_md  input  1  ID-stage instruction is mult/div-class (IDMULDIV_Type)
- start  output  1  combinational; high in the cycle a mult/multu/div/divu is accepted
- busy  output  1  registered; high while a started operation is counting
- stall  output  1  combinational; id_md & (start | busy)
- out  output  32  combinational; HI for op 7, LO for op 8 when op_valid, else 0
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Reset (async, any state): state=IDLE, count=0, busy=0, HI=LO=0, pending results discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE with op_valid and op in 1..4:
  - start=1.
  - Compute the result from a/b and latch it into pend_hi/pend_lo.
  - Latch the div-by-zero flag.
  - count <= LAT (MUL_LAT for ops 1-2, DIV_LAT for ops 3-4).
  - state <= RUN.
  - busy is high starting the next cycle.
- RUN, each edge:
  - count decrements.
  - When count==1 at the edge: HI<=pend_hi, LO<=pend_lo (skipped if the div-by-zero flag is set), state<=IDLE.
  - busy is high for exactly LAT cycles; the new HI/LO is visible in the first cycle busy=0.
- mult: signed 64-bit product, HI=[63:32], LO=[31:0]. multu: unsigned product, same split.
- div:
  - LO = signed quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero: full DIV_LAT busy period, HI/LO unchanged.
- mthi/mtlo in IDLE: HI (resp. LO) <= a at the next edge. No busy.
- op_valid in RUN: start=0; the operation is ignored and HI/LO are not written. Hazard logic guarantees this never happens; the block still must not corrupt state.
- mfhi/mflo during RUN: out returns the old HI/LO; stalling is the hazard unit's job via stall.
- start and stall are combinational from op_valid/op/id_md/state; no registered path from a/b to stall.
- Reset during RUN: immediate return to IDLE, busy=0 in the same cycle, HI/LO=0, commit lost.

Test Plan:
- After reset, mthi a=0x1234, then mflo → hi=0x1234, out on mflo = 0, busy never asserted.
- mult a=0xFFFFFFFE (-2), b=3, id_md held high:
  - start=1 in cycle 0; busy=1 in cycles 1-5; stall=1 in cycles 0-5.
  - Cycle 6: busy=0, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2 → after 5 busy cycles HI=1, LO=0xFFFFFFFE.
- div a=-7 (0xFFFFFFF9), b=2 → busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- divu a=5, b=0 after HI=LO=0xA5 → busy 10 cycles, then HI/LO still 0xA5.
- Reset asserted at busy cycle 3 of a div → busy=0 immediately, HI=LO=0, no later commit.
- Further checks:
  - mult issued while busy → state unchanged.
  - mfhi during busy returns the old HI.

Source files
------------

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, models unit latency with a countdown and
// raises a stall toward the hazard logic while a mult/div is in flight.
module md_sequencer #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        id_md,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_busy;
  logic          r_dz;
  logic [31:0]   r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic          w_is_md, w_commit, w_dz;
  logic [63:0]   w_prod;
  logic [31:0]   w_res_hi, w_res_lo;

  assign w_is_md = op_valid && (op >= 4'd1) && (op <= 4'd4);
  assign w_dz    = (b == 32'd0);

  // Arithmetic result of the operation presented on a/b
  always_comb begin
    w_prod   = 64'd0;
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (op)
      4'd1: begin
        // Low 64 bits of a sign-extended product equal the signed product
        w_prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
      end
      4'd2: begin
        w_prod   = {32'd0, a} * {32'd0, b};
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
      end
      4'd3: begin
        if (w_dz) begin
          w_res_hi = 32'd0;
          w_res_lo = 32'd0;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          w_res_hi = 32'd0;
          w_res_lo = 32'h8000_0000;
        end else begin
          w_res_hi = $signed(a) % $signed(b);
          w_res_lo = $signed(a) / $signed(b);
        end
      end
      4'd4: begin
        if (w_dz) begin
          w_res_hi = 32'd0;
          w_res_lo = 32'd0;
        end else begin
          w_res_hi = a % b;
          w_res_lo = a / b;
        end
      end
      default: begin
        w_prod = 64'd0;
      end
    endcase
  end

  // Next-state, countdown and start decode
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    start       = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_is_md) begin
          start       = 1'b1;
          w_count_nxt = (op <= 4'd2) ? MUL_CNT : DIV_CNT;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_count_nxt = r_count - CNT_ONE;
        if (r_count == CNT_ONE) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // State, countdown, pending result and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_dz      <= 1'b0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      if (start) begin
        r_pend_hi <= w_res_hi;
        r_pend_lo <= w_res_lo;
        r_dz      <= w_dz && (op >= 4'd3);
      end
      if (w_commit && !r_dz) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end else if ((r_state == S_IDLE) && op_valid) begin
        if (op == 4'd5) r_hi <= a;
        if (op == 4'd6) r_lo <= a;
      end
    end
  end

  assign busy  = r_busy;
  assign stall = id_md && (start || r_busy);
  assign hi    = r_hi;
  assign lo    = r_lo;

  // Move-from read port; reads the architectural HI/LO even mid-operation
  always_comb begin
    out = 32'd0;
    if (op_valid && (op == 4'd7)) begin
      out = r_hi;
    end else if (op_valid && (op == 4'd8)) begin
      out = r_lo;
    end else begin
      out = 32'd0;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed plan steps and random traffic against a
// cycle-level reference model built on 64-bit integer arithmetic.
module tb_md_sequencer;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        id_md;
  logic        start, busy, stall;
  logic [31:0] out, hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int          rem = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  bit          p_dz = 1'b0;

  md_sequencer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .a(a), .b(b),
    .id_md(id_md), .start(start), .busy(busy), .stall(stall), .out(out),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // What the unit does on the coming rising edge, computed from the rules.
  task automatic model_edge(input logic v, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (rem > 0) begin
      rem--;
      if (rem == 0 && !p_dz) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (v) begin
      case (o)
        4'd1: begin sq = sx * sy; p_hi = sq[63:32]; p_lo = sq[31:0]; p_dz = 0; rem = MUL_LAT; end
        4'd2: begin up = ux * uy; p_hi = up[63:32]; p_lo = up[31:0]; p_dz = 0; rem = MUL_LAT; end
        4'd3: begin
          p_dz = (y == 32'd0);
          if (!p_dz) begin sq = sx / sy; sr = sx % sy; p_hi = sr[31:0]; p_lo = sq[31:0]; end
          rem = DIV_LAT;
        end
        4'd4: begin
          p_dz = (y == 32'd0);
          if (!p_dz) begin up = ux / uy; p_lo = up[31:0]; up = ux % uy; p_hi = up[31:0]; end
          rem = DIV_LAT;
        end
        4'd5: m_hi = x;
        4'd6: m_lo = x;
        default: ;
      endcase
    end
  endtask

  // One clock: drive at the falling edge, check settled outputs, advance the model.
  task automatic cyc(input logic v, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic id);
    logic e_start, e_busy;
    logic [31:0] e_out;
    @(negedge clk);
    op_valid = v; op = o; a = x; b = y; id_md = id;
    #1;
    e_busy  = (rem > 0);
    e_start = !e_busy && v && (o >= 4'd1) && (o <= 4'd4);
    e_out   = (v && o == 4'd7) ? m_hi : (v && o == 4'd8) ? m_lo : 32'd0;
    chk("start", {31'd0, start}, {31'd0, e_start});
    chk("busy",  {31'd0, busy},  {31'd0, e_busy});
    chk("stall", {31'd0, stall}, {31'd0, id & (e_start | e_busy)});
    chk("out", out, e_out);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    model_edge(v, o, x, y);
  endtask

  task automatic idle(input int n, input logic id);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0, id);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; id_md = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // mthi then mflo
    cyc(1'b1, 4'd5, 32'h1234, 32'd0, 1'b0);
    cyc(1'b1, 4'd8, 32'd0, 32'd0, 1'b0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mflo_out", out, 32'd0);

    // mult -2 * 3 with id_md held
    cyc(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    chk("mult_start", {31'd0, start}, 32'd1);
    idle(MUL_LAT, 1'b1);
    idle(1, 1'b1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // multu
    cyc(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    idle(MUL_LAT + 1, 1'b0);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // div -7/2, with a mult and mfhi issued mid-operation
    cyc(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle(2, 1'b1);
    cyc(1'b1, 4'd1, 32'd9, 32'd9, 1'b1);
    cyc(1'b1, 4'd7, 32'd0, 32'd0, 1'b1);
    chk("mfhi_busy", out, 32'd1);
    idle(DIV_LAT - 3, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    // overflow case
    cyc(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DIV_LAT + 1, 1'b0);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'd0);

    // divide by zero leaves HI/LO alone
    cyc(1'b1, 4'd5, 32'hA5, 32'd0, 1'b0);
    cyc(1'b1, 4'd6, 32'hA5, 32'd0, 1'b0);
    cyc(1'b1, 4'd4, 32'd5, 32'd0, 1'b0);
    idle(DIV_LAT + 1, 1'b0);
    chk("dz_hi", hi, 32'hA5);
    chk("dz_lo", lo, 32'hA5);

    // reset in busy cycle 3 of a div
    cyc(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
    idle(3, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    rem = 0; m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    idle(DIV_LAT, 1'b0);
    chk("no_commit_lo", lo, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 9)), pick(), pick(), 1'($urandom_range(0, 1)));
    end
    idle(DIV_LAT + 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
